tm1638_device: RTL

- Synthesizable model of the TM1638 chip side of the serial link: the responder that the tm1638 controller drives.
- Oversamples STB/CLK/DIO with the system clock and decodes data, display-control and address commands.
- Stores 16 bytes of display RAM and shifts out a 32-bit key snapshot on a read command.
- Used as an on-FPGA loopback target and as the reference responder in controller benches.

---
 rtl/tm1638_device.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tm1638_device.sv
// tm1638_device: TM1638 chip-side serial responder with display RAM, display control and key readout.
module tm1638_device #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        sclk,
  input  logic        dio_in,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic [31:0] keys,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        cmd_err
);
  typedef enum logic [2:0] {IDLE, CMD, DATA, READ, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] stb_s, sclk_s, dio_s;
  logic        stb_q, sclk_q;
  logic [7:0]  ram [16];
  logic [7:0]  sh;
  logic [3:0]  bit_cnt;
  logic [5:0]  rd_cnt;
  logic [31:0] snap;
  logic [3:0]  addr;
  logic        mode, fixed;
  logic        stb_i, sclk_i, dio_i, stb_fall, sclk_rise, sclk_fall, byte_done;
  assign stb_i     = stb_s[SYNC_STAGES-1];
  assign sclk_i    = sclk_s[SYNC_STAGES-1];
  assign dio_i     = dio_s[SYNC_STAGES-1];
  assign stb_fall  = !stb_i && stb_q;
  assign sclk_rise = sclk_i && !sclk_q;
  assign sclk_fall = !sclk_i && sclk_q;
  assign byte_done = !stb_i && bit_cnt == 4'd8 && (state == CMD || state == DATA);
  assign rd_data   = ram[rd_addr];
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (stb_i)
      state_n = IDLE;
    else if (stb_fall)
      state_n = CMD;
    else if (byte_done && state == CMD)
      state_n = sh[7:6] == 2'b01 ? (sh[1] ? READ : DATA) :
                sh[7:6] == 2'b11 ? DATA : IGNORE;
    else if (state == READ && sclk_fall && rd_cnt == 6'd32)
      state_n = IGNORE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_s      <= '1;
      sclk_s     <= '1;
      dio_s      <= '1;
      stb_q      <= 1'b1;
      sclk_q     <= 1'b1;
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      sh         <= 8'h00;
      bit_cnt    <= 4'd0;
      rd_cnt     <= 6'd0;
      snap       <= 32'h0;
      addr       <= 4'd0;
      mode       <= 1'b0;
      fixed      <= 1'b0;
      display_on <= 1'b0;
      brightness <= 3'd0;
      dio_out    <= 1'b1;
      dio_oe     <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      stb_s   <= {stb_s[SYNC_STAGES-2:0], stb};
      sclk_s  <= {sclk_s[SYNC_STAGES-2:0], sclk};
      dio_s   <= {dio_s[SYNC_STAGES-2:0], dio_in};
      stb_q   <= stb_i;
      sclk_q  <= sclk_i;
      cmd_err <= 1'b0;
      if (stb_i) begin
        bit_cnt <= 4'd0;
        dio_oe  <= 1'b0;
        dio_out <= 1'b1;
      end else if (stb_fall) begin
        bit_cnt <= 4'd0;
      end else if (byte_done) begin
        bit_cnt <= 4'd0;
        if (state == CMD) begin
          if (sh[7:6] == 2'b01) begin
            mode  <= sh[1];
            fixed <= sh[2];
            if (sh[1]) begin
              snap    <= keys;
              rd_cnt  <= 6'd0;
              dio_oe  <= 1'b1;
              dio_out <= keys[0];
            end
          end else if (sh[7:6] == 2'b10) begin
            display_on <= sh[3];
            brightness <= sh[2:0];
          end else if (sh[7:6] == 2'b11) begin
            addr <= sh[3:0];
          end else begin
            cmd_err <= 1'b1;
          end
        end else if (!mode) begin
          ram[addr] <= sh;
          if (!fixed) addr <= addr + 4'd1;
        end
      end else if (sclk_rise && (state == CMD || state == DATA)) begin
        sh[bit_cnt[2:0]] <= dio_i;
        bit_cnt          <= bit_cnt + 4'd1;
      end else if (state == READ) begin
        // bit n is presented on the falling edge after n rising edges; the first fall keeps bit 0
        if (sclk_rise && rd_cnt != 6'd32) rd_cnt <= rd_cnt + 6'd1;
        if (sclk_fall) begin
          dio_oe  <= rd_cnt != 6'd32;
          dio_out <= rd_cnt == 6'd32 ? 1'b1 : snap[rd_cnt[4:0]];
        end
      end
    end
  end
endmodule
